// File: rtl/regfile_write_queue_pkg.sv
// Shared types and constants for the register-file write queue.
package regfile_write_queue_pkg;

    localparam int WQ_ADDR_W = 5;
    localparam int WQ_DATA_W = 32;

    localparam logic [WQ_ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                 live;
        logic [WQ_ADDR_W-1:0] wnum;
        logic [WQ_DATA_W-1:0] wdata;
    } wq_slot_t;

endpackage

// File: rtl/regfile_write_queue_match.sv
// Per-slot comparator: a slot matches a key when it is live and targets that register.
module wq_match #(
    parameter int ADDR_W = 5
) (
    input  logic              live,
    input  logic [ADDR_W-1:0] wnum,
    input  logic [ADDR_W-1:0] key,
    output logic              hit
);

    assign hit = live & (wnum == key);

endmodule

// File: rtl/regfile_write_queue.sv
// Merges pipeline writeback and queued long-latency results onto one register-file write port.
// Optional WB_BYPASS_EN macro builds the youngest-entry forwarding lookup.
module regfile_write_queue
    import regfile_write_queue_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = WQ_DATA_W,
    parameter int ADDR_W = WQ_ADDR_W
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 p_write,
    input  logic [ADDR_W-1:0]    p_wnum,
    input  logic [DATA_W-1:0]    p_wdata,
    input  logic                 q_valid,
    input  logic [ADDR_W-1:0]    q_wnum,
    input  logic [DATA_W-1:0]    q_wdata,
    output logic                 q_ready,
    output logic                 rf_write,
    output logic [ADDR_W-1:0]    rf_wnum,
    output logic [DATA_W-1:0]    rf_wdata,
    output logic [2**ADDR_W-1:0] pending,
    output logic                 full,
    output logic                 empty,
    input  logic [ADDR_W-1:0]    fwd_num,
    output logic                 fwd_hit,
    output logic [DATA_W-1:0]    fwd_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NREG  = 2**ADDR_W;

    wq_slot_t         slot_q [DEPTH];
    wq_slot_t         slot_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             push_en, pop_en, kill_en;
    logic [DEPTH-1:0] kill_hit;
    logic [NREG-1:1][DEPTH-1:0] pend_m;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign q_ready = !reset && !full;

    // r0 writes complete the handshake but are never stored.
    assign push_en = q_valid && q_ready && (q_wnum != REG_ZERO);
    assign pop_en  = !reset && !p_write && !empty;
    assign kill_en = !reset && p_write && (p_wnum != REG_ZERO);

    genvar gi, gr;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            wq_match #(.ADDR_W(ADDR_W)) u_kill (
                .live (slot_q[gi].live),
                .wnum (slot_q[gi].wnum),
                .key  (p_wnum),
                .hit  (kill_hit[gi])
            );
            for (gr = 1; gr < NREG; gr++) begin : g_reg
                wq_match #(.ADDR_W(ADDR_W)) u_pend (
                    .live (slot_q[gi].live),
                    .wnum (slot_q[gi].wnum),
                    .key  (ADDR_W'(gr)),
                    .hit  (pend_m[gr][gi])
                );
            end
        end
        for (gr = 1; gr < NREG; gr++) begin : g_pend
            assign pending[gr] = |pend_m[gr];
        end
    endgenerate
    assign pending[0] = 1'b0;

    always_comb begin
        slot_d  = slot_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (kill_en && kill_hit[i]) slot_d[i].live = 1'b0;
        end
        if (pop_en) begin
            slot_d[head_q].live = 1'b0;
            head_d = head_q + PTR_W'(1);
        end
        // A pipeline write in the same cycle is younger, so a same-register push lands dead.
        if (push_en) begin
            slot_d[tail_q].live  = !(kill_en && (p_wnum == q_wnum));
            slot_d[tail_q].wnum  = q_wnum;
            slot_d[tail_q].wdata = q_wdata;
            tail_d = tail_q + PTR_W'(1);
        end
        if (push_en && !pop_en)      count_d = count_q + CNT_W'(1);
        else if (!push_en && pop_en) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) slot_q[i].live <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            slot_q  <= slot_d;
        end
    end

    always_comb begin
        rf_write = 1'b0;
        rf_wnum  = '0;
        rf_wdata = '0;
        if (reset) begin
            rf_write = 1'b0;
        end else if (p_write) begin
            rf_write = 1'b1;
            rf_wnum  = p_wnum;
            rf_wdata = p_wdata;
        end else if (!empty) begin
            rf_write = slot_q[head_q].live;
            rf_wnum  = slot_q[head_q].wnum;
            rf_wdata = slot_q[head_q].wdata;
        end
    end

`ifdef WB_BYPASS_EN
    logic [DEPTH-1:0] fwd_m;
    logic [PTR_W-1:0] fwd_idx;

    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_fwd
            wq_match #(.ADDR_W(ADDR_W)) u_fwd (
                .live (slot_q[gi].live),
                .wnum (slot_q[gi].wnum),
                .key  (fwd_num),
                .hit  (fwd_m[gi])
            );
        end
    endgenerate

    // Walk oldest to youngest so the entry nearest the tail wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = head_q;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = head_q + PTR_W'(k);
            if (fwd_m[fwd_idx] && (fwd_num != REG_ZERO)) begin
                fwd_hit  = 1'b1;
                fwd_data = slot_q[fwd_idx].wdata;
            end
        end
    end
`else
    logic fwd_unused;
    assign fwd_unused = ^fwd_num;
    assign fwd_hit    = 1'b0;
    assign fwd_data   = '0;
`endif

endmodule

// File: tb/tb_regfile_write_queue.sv
// Randomized + directed bench for regfile_write_queue against a queue-based reference model.
module tb_regfile_write_queue;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        p_write;
    logic [4:0]  p_wnum;
    logic [31:0] p_wdata;
    logic        q_valid;
    logic [4:0]  q_wnum;
    logic [31:0] q_wdata;
    logic        q_ready;
    logic        rf_write;
    logic [4:0]  rf_wnum;
    logic [31:0] rf_wdata;
    logic [31:0] pending;
    logic        full;
    logic        empty;
    logic [4:0]  fwd_num;
    logic        fwd_hit;
    logic [31:0] fwd_data;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        bit          live;
        logic [4:0]  wnum;
        logic [31:0] wdata;
    } ent_t;

    ent_t mq[$];

    regfile_write_queue #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
        .clock    (clock),
        .reset    (reset),
        .p_write  (p_write),
        .p_wnum   (p_wnum),
        .p_wdata  (p_wdata),
        .q_valid  (q_valid),
        .q_wnum   (q_wnum),
        .q_wdata  (q_wdata),
        .q_ready  (q_ready),
        .rf_write (rf_write),
        .rf_wnum  (rf_wnum),
        .rf_wdata (rf_wdata),
        .pending  (pending),
        .full     (full),
        .empty    (empty),
        .fwd_num  (fwd_num),
        .fwd_hit  (fwd_hit),
        .fwd_data (fwd_data)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL cyc %0d %s: got %0h expected %0h", cyc, tag, got, exp);
        end
    endtask

    // One clock of stimulus: drive, check outputs mid-cycle against the model, then advance the model.
    task automatic step(input logic rst, input logic pw, input logic [4:0] pwn, input logic [31:0] pwd,
                        input logic qv, input logic [4:0] qwn, input logic [31:0] qwd,
                        input logic [4:0] fn);
        bit          e_ready, e_w, e_hit, accept;
        logic [4:0]  e_n;
        logic [31:0] e_d, e_pend, e_fd;
        reset = rst; p_write = pw; p_wnum = pwn; p_wdata = pwd;
        q_valid = qv; q_wnum = qwn; q_wdata = qwd; fwd_num = fn;
        @(negedge clock);

        e_ready = !rst && (mq.size() < DEPTH);
        e_w = 1'b0; e_n = '0; e_d = '0;
        if (!rst && pw) begin
            e_w = 1'b1; e_n = pwn; e_d = pwd;
        end else if (!rst && mq.size() > 0) begin
            e_w = mq[0].live; e_n = mq[0].wnum; e_d = mq[0].wdata;
        end
        e_pend = '0;
        e_hit  = 1'b0;
        e_fd   = '0;
        foreach (mq[i]) begin
            if (mq[i].live) e_pend[mq[i].wnum] = 1'b1;
        end
`ifdef WB_BYPASS_EN
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (!e_hit && mq[i].live && mq[i].wnum == fn && fn != 0) begin
                e_hit = 1'b1;
                e_fd  = mq[i].wdata;
            end
        end
`endif
        check("q_ready", 64'(q_ready), 64'(e_ready));
        check("rf_write", 64'(rf_write), 64'(e_w));
        if (!rst) begin
            check("rf_wnum", 64'(rf_wnum), 64'(e_n));
            check("rf_wdata", 64'(rf_wdata), 64'(e_d));
        end
        check("pending", 64'(pending), 64'(e_pend));
        check("full", 64'(full), 64'(mq.size() == DEPTH));
        check("empty", 64'(empty), 64'(mq.size() == 0));
        check("fwd_hit", 64'(fwd_hit), 64'(e_hit));
        check("fwd_data", 64'(fwd_data), 64'(e_fd));
        $display("cyc %0d rst=%0d pw=%0d r%0d q_v=%0d r%0d rdy=%0d -> rf_write=%0d r%0d %08h depth=%0d",
                 cyc, rst, pw, pwn, qv, qwn, q_ready, rf_write, rf_wnum, rf_wdata, mq.size());

        @(posedge clock);
        accept = qv && e_ready;
        if (rst) begin
            mq.delete();
        end else begin
            if (pw && pwn != 0) begin
                foreach (mq[i]) if (mq[i].wnum == pwn) mq[i].live = 1'b0;
            end
            if (!pw && mq.size() > 0) void'(mq.pop_front());
            if (accept && qwn != 0)
                mq.push_back('{live: !(pw && pwn != 0 && pwn == qwn), wnum: qwn, wdata: qwd});
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1; p_write = 0; p_wnum = 0; p_wdata = 0;
        q_valid = 0; q_wnum = 0; q_wdata = 0; fwd_num = 0;
        @(posedge clock);
        #1;
        step(1, 0, 0, 0, 1, 4, 32'h1, 0);

        // Idle write port: push then drain next cycle.
        step(0, 0, 0, 0, 1, 5, 32'hAAAA0001, 5);
        idle(2);

        // Priority and fill: pipeline owns the port while the queue fills.
        for (int k = 0; k < 6; k++)
            step(0, 1, 5'(10 + k), 32'h100 + k, 1, 5'(1 + k), 32'h5000 + k, 0);
        idle(6);

        // Kill of an older queued entry.
        step(0, 1, 2, 32'h2, 1, 7, 32'h11, 0);
        step(0, 1, 2, 32'h2, 1, 8, 32'h22, 7);
        step(0, 1, 7, 32'h99, 0, 0, 0, 7);
        idle(3);

        // Same-cycle kill of an incoming entry.
        step(0, 1, 9, 32'h9, 1, 9, 32'h909, 9);
        idle(2);

        // r0 push, then reset mid-drain with three entries queued.
        step(0, 0, 0, 0, 1, 0, 32'hDEAD, 0);
        step(0, 1, 1, 32'h1, 1, 12, 32'hC, 12);
        step(0, 1, 1, 32'h1, 1, 13, 32'hD, 13);
        step(0, 1, 1, 32'h1, 1, 14, 32'hE, 14);
        step(1, 0, 0, 0, 1, 15, 32'hF, 0);
        idle(3);

        // Forwarding picks the youngest of two same-register entries.
        step(0, 1, 1, 32'h1, 1, 3, 32'h10, 3);
        step(0, 1, 1, 32'h1, 1, 3, 32'h20, 3);
        step(0, 1, 1, 32'h1, 0, 0, 0, 3);
        idle(3);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 99) < 35, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)));
        end
        idle(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
